// File: rtl/agc_mem_pkg.sv
// Shared definitions for the erasable-memory port arbiter.
//   AGC_ADDR_W / AGC_DATA_W : default word address / word width (15 data + parity)
//   REQ_*                   : requester bit positions in request/grant vectors
//   arb_state_e             : arbiter FSM encoding
package agc_mem_pkg;

  localparam int unsigned AGC_ADDR_W = 12;
  localparam int unsigned AGC_DATA_W = 16;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned REQ_SEQ = 0;
  localparam int unsigned REQ_CNT = 1;
  localparam int unsigned REQ_IO  = 2;

  // Width of the burst and starvation counters (limits are 1..15)
  localparam int unsigned CTR_W   = 4;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

endpackage : agc_mem_pkg

// File: rtl/mem_port_arbiter_prio_select3.sv
// Combinational three-way priority select.
//   i_req   : qualified request vector (indexed by REQ_*)
//   i_promo : promotion vector; promoted requesters are served first
//   o_gnt_c : one-hot (or zero) grant
// Order: promoted cnt, promoted io, promoted seq, then seq, io, cnt.
module prio_select3
  import agc_mem_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_promo,
  output logic [NUM_REQ-1:0] o_gnt_c
);

  logic [NUM_REQ-1:0] w_hot;

  assign w_hot = i_req & i_promo;

  always_comb begin
    o_gnt_c = '0;
    if (w_hot[REQ_CNT])       o_gnt_c[REQ_CNT] = 1'b1;
    else if (w_hot[REQ_IO])   o_gnt_c[REQ_IO]  = 1'b1;
    else if (w_hot[REQ_SEQ])  o_gnt_c[REQ_SEQ] = 1'b1;
    else if (i_req[REQ_SEQ])  o_gnt_c[REQ_SEQ] = 1'b1;
    else if (i_req[REQ_IO])   o_gnt_c[REQ_IO]  = 1'b1;
    else if (i_req[REQ_CNT])  o_gnt_c[REQ_CNT] = 1'b1;
  end

endmodule : prio_select3

// File: rtl/mem_port_arbiter.sv
// Erasable-memory port arbiter: shares one synchronous single-port RAM between
// the control-pulse sequencer (seq), the counter-increment unit (cnt) and the
// DSKY I/O channel (io). One access per cycle, read data routed back by rvalid.
//   clk, rst_n                 : clock, async active-low reset
//   {seq,cnt,io}_req/we/addr/wdata : level-held requests
//   cnt_lock                   : with a cnt read, holds the port for the cnt write
//   {seq,cnt,io}_gnt           : same-cycle grant (one-hot or zero)
//   {seq,cnt,io}_rvalid, rdata : read return one cycle after the grant
//   mem_en/we/addr/wdata       : RAM command (same cycle as the grant)
//   mem_rdata                  : RAM read data, valid the cycle after a read
module mem_port_arbiter
  import agc_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = AGC_ADDR_W,
  parameter int unsigned DATA_W     = AGC_DATA_W,
  parameter int unsigned CNT_BURST  = 4,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              seq_req,
  input  logic              seq_we,
  input  logic [ADDR_W-1:0] seq_addr,
  input  logic [DATA_W-1:0] seq_wdata,

  input  logic              cnt_req,
  input  logic              cnt_we,
  input  logic [ADDR_W-1:0] cnt_addr,
  input  logic [DATA_W-1:0] cnt_wdata,
  input  logic              cnt_lock,

  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,

  output logic              seq_gnt,
  output logic              cnt_gnt,
  output logic              io_gnt,

  output logic              seq_rvalid,
  output logic              cnt_rvalid,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CTR_W-1:0] BURST_MAX  = CTR_W'(CNT_BURST);
  localparam logic [CTR_W-1:0] STARVE_MAX = CTR_W'(STARVE_LIM);
  localparam logic [CTR_W-1:0] WAIT_SAT   = {CTR_W{1'b1}};

  arb_state_e          r_state;
  logic [CTR_W-1:0]    r_burst_cnt;
  logic [CTR_W-1:0]    r_io_wait;
  logic [NUM_REQ-1:0]  r_rvalid;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_burst_full;
  logic                w_io_starved;
  logic [NUM_REQ-1:0]  w_req;
  logic [NUM_REQ-1:0]  w_promo;
  logic [NUM_REQ-1:0]  w_gnt;
  logic                w_any_gnt;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  assign w_burst_full = (r_burst_cnt == BURST_MAX);
  assign w_io_starved = (r_io_wait >= STARVE_MAX);

  // Qualified requests: nothing during reset, only cnt while locked,
  // cnt yields to a waiting seq once its burst is used up.
  always_comb begin
    w_req = '0;
    if (rst_n) begin
      if (r_state == LOCK) begin
        w_req[REQ_CNT] = cnt_req;
      end else begin
        w_req[REQ_SEQ] = seq_req;
        w_req[REQ_IO]  = io_req;
        w_req[REQ_CNT] = cnt_req && !(w_burst_full && seq_req);
      end
    end
  end

  // cnt always sits on top; a starved io jumps ahead of seq only
  always_comb begin
    w_promo          = '0;
    w_promo[REQ_CNT] = 1'b1;
    w_promo[REQ_IO]  = w_io_starved;
  end

  prio_select3 u_prio (
    .i_req   (w_req),
    .i_promo (w_promo),
    .o_gnt_c (w_gnt)
  );

  assign seq_gnt   = w_gnt[REQ_SEQ];
  assign cnt_gnt   = w_gnt[REQ_CNT];
  assign io_gnt    = w_gnt[REQ_IO];
  assign w_any_gnt = |w_gnt;

  // Command mux from the one-hot grant
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    if (w_gnt[REQ_CNT]) begin
      w_sel_we    = cnt_we;
      w_sel_addr  = cnt_addr;
      w_sel_wdata = cnt_wdata;
    end else if (w_gnt[REQ_SEQ]) begin
      w_sel_we    = seq_we;
      w_sel_addr  = seq_addr;
      w_sel_wdata = seq_wdata;
    end else if (w_gnt[REQ_IO]) begin
      w_sel_we    = io_we;
      w_sel_addr  = io_addr;
      w_sel_wdata = io_wdata;
    end
  end

  // Address/data hold their last value when the port is idle
  assign mem_en    = w_any_gnt;
  assign mem_we    = w_any_gnt & w_sel_we;
  assign mem_addr  = w_any_gnt ? w_sel_addr  : r_addr;
  assign mem_wdata = w_any_gnt ? w_sel_wdata : r_wdata;

  assign seq_rvalid = r_rvalid[REQ_SEQ];
  assign cnt_rvalid = r_rvalid[REQ_CNT];
  assign io_rvalid  = r_rvalid[REQ_IO];
  assign rdata      = (|r_rvalid) ? mem_rdata : '0;

  // FSM, fairness counters, read-return tag and command hold registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ARB;
      r_burst_cnt <= '0;
      r_io_wait   <= '0;
      r_rvalid    <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      case (r_state)
        ARB:     if (w_gnt[REQ_CNT] && !cnt_we && cnt_lock) r_state <= LOCK;
        LOCK:    if (w_gnt[REQ_CNT] && cnt_we)              r_state <= ARB;
        default: r_state <= ARB;
      endcase

      if (w_gnt[REQ_SEQ] || !cnt_req) begin
        r_burst_cnt <= '0;
      end else if (w_gnt[REQ_CNT] && !w_burst_full) begin
        r_burst_cnt <= CTR_W'(r_burst_cnt + CTR_W'(1));
      end

      if (!io_req || w_gnt[REQ_IO]) begin
        r_io_wait <= '0;
      end else if (r_io_wait != WAIT_SAT) begin
        r_io_wait <= CTR_W'(r_io_wait + CTR_W'(1));
      end

      r_rvalid <= w_gnt & {NUM_REQ{~w_sel_we}};

      if (w_any_gnt) begin
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
    end
  end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a write-first RAM model and
// a read-return scoreboard.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam logic [2:0] G_SEQ  = 3'b001;
  localparam logic [2:0] G_CNT  = 3'b010;
  localparam logic [2:0] G_IO   = 3'b100;
  localparam logic [2:0] G_NONE = 3'b000;

  logic clk = 1'b0;
  logic rst_n;
  logic seq_req, seq_we, cnt_req, cnt_we, cnt_lock, io_req, io_we;
  logic [ADDR_W-1:0] seq_addr, cnt_addr, io_addr;
  logic [DATA_W-1:0] seq_wdata, cnt_wdata, io_wdata;
  logic seq_gnt, cnt_gnt, io_gnt, seq_rvalid, cnt_rvalid, io_rvalid;
  logic [DATA_W-1:0] rdata;
  logic mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic pre_en;
  logic [ADDR_W-1:0] pre_addr;
  logic [DATA_W-1:0] pre_data;
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  typedef struct packed {
    logic [2:0]        who;
    logic [DATA_W-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  wire [2:0] gnt_v    = {io_gnt, cnt_gnt, seq_gnt};
  wire [2:0] rvalid_v = {io_rvalid, cnt_rvalid, seq_rvalid};

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_BURST(4), .STARVE_LIM(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .seq_req(seq_req), .seq_we(seq_we), .seq_addr(seq_addr), .seq_wdata(seq_wdata),
    .cnt_req(cnt_req), .cnt_we(cnt_we), .cnt_addr(cnt_addr), .cnt_wdata(cnt_wdata),
    .cnt_lock(cnt_lock),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .seq_gnt(seq_gnt), .cnt_gnt(cnt_gnt), .io_gnt(io_gnt),
    .seq_rvalid(seq_rvalid), .cnt_rvalid(cnt_rvalid), .io_rvalid(io_rvalid),
    .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous write-first RAM plus a backdoor preload port
  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        mem_rdata     <= mem_wdata;
      end else begin
        mem_rdata     <= ram[mem_addr];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    seq_req = 1'b0; cnt_req = 1'b0; io_req = 1'b0; cnt_lock = 1'b0;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    step();
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_en = 1'b0;
  endtask

  // Pops the scoreboard whenever any rvalid is seen
  task automatic monitor_rvalid();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rvalid_v != 3'b000) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rvalid_unexpected: rvalid=%b rdata=%h, none expected", rvalid_v, rdata);
        end else begin
          e = exp_q.pop_front();
          if (rvalid_v !== e.who || rdata !== e.data) begin
            errors++;
            $display("FAIL read_return: rvalid=%b rdata=%h, expected rvalid=%b rdata=%h",
                     rvalid_v, rdata, e.who, e.data);
          end
        end
      end
    end
  endtask

  task automatic check_drained(input string name);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d reads never returned, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_gnt(input string name, input int cyc, input logic [2:0] exp);
    checks++;
    if (gnt_v !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: gnt=%b, expected %b", name, cyc, gnt_v, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    seq_req = 1'b1; seq_we = 1'b1; seq_addr = 12'h7F0; seq_wdata = 16'h1111;
    cnt_req = 1'b1; cnt_we = 1'b1; cnt_addr = 12'h7F1; cnt_wdata = 16'h2222; cnt_lock = 1'b0;
    io_req  = 1'b1; io_we  = 1'b1; io_addr  = 12'h7F2; io_wdata  = 16'h3333;
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt_v, rvalid_v, mem_en, mem_we} !== 8'h00 || mem_addr !== 12'h000 ||
        mem_wdata !== 16'h0000 || rdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b rvalid=%b en=%b we=%b addr=%h wd=%h rd=%h, expected all 0",
               gnt_v, rvalid_v, mem_en, mem_we, mem_addr, mem_wdata, rdata);
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_gnt("reset_release", 0, G_CNT);
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 12'h7F1) begin
      errors++;
      $display("FAIL reset_release_cmd: en=%b addr=%h, expected en=1 addr=7f1", mem_en, mem_addr);
    end
    step();
    idle();
    check_drained("reset");
  endtask

  task automatic test_seq_read();
    step();
    seq_req = 1'b1; seq_we = 1'b0; seq_addr = 12'h040;
    exp_q.push_back('{who: G_SEQ, data: 16'h1234});
    @(negedge clk);
    check_gnt("seq_read", 0, G_SEQ);
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h040) begin
      errors++;
      $display("FAIL seq_read_cmd: en=%b we=%b addr=%h, expected en=1 we=0 addr=040",
               mem_en, mem_we, mem_addr);
    end
    step();
    idle();
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b0 || mem_addr !== 12'h040) begin
      errors++;
      $display("FAIL idle_hold: en=%b addr=%h, expected en=0 addr=040", mem_en, mem_addr);
    end
    check_drained("seq_read");
  endtask

  task automatic test_burst();
    logic [2:0] pat [10];
    pat = '{G_CNT, G_CNT, G_CNT, G_CNT, G_SEQ, G_CNT, G_CNT, G_CNT, G_CNT, G_SEQ};
    step();
    seq_req = 1'b1; seq_we = 1'b1; seq_addr = 12'h100; seq_wdata = 16'hAAAA;
    cnt_req = 1'b1; cnt_we = 1'b1; cnt_addr = 12'h101; cnt_wdata = 16'h5555;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_gnt("burst", i, pat[i]);
      step();
    end
    idle();
  endtask

  task automatic test_starve();
    step();
    seq_req = 1'b1; seq_we = 1'b1; seq_addr = 12'h110; seq_wdata = 16'h0101;
    io_req  = 1'b1; io_we  = 1'b1; io_addr  = 12'h111; io_wdata  = 16'h0202;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_gnt("starve", i, (i == 8) ? G_IO : G_SEQ);
      step();
    end
    idle();
  endtask

  task automatic test_cnt_keeps_port();
    step();
    cnt_req = 1'b1; cnt_we = 1'b1; cnt_addr = 12'h120; cnt_wdata = 16'h0F0F;
    io_req  = 1'b1; io_we  = 1'b1; io_addr  = 12'h121; io_wdata  = 16'hF0F0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_gnt("cnt_vs_io", i, G_CNT);
      step();
    end
    cnt_req = 1'b0;
    @(negedge clk);
    check_gnt("cnt_vs_io", 12, G_IO);
    step();
    idle();
  endtask

  task automatic test_lock_rmw();
    step();
    cnt_req = 1'b1; cnt_we = 1'b0; cnt_lock = 1'b1; cnt_addr = 12'h024;
    seq_req = 1'b1; seq_we = 1'b0; seq_addr = 12'h040;
    exp_q.push_back('{who: G_CNT, data: 16'h0007});
    @(negedge clk);
    check_gnt("lock", 0, G_CNT);
    for (int i = 1; i < 3; i++) begin
      step();
      cnt_req = 1'b0; cnt_lock = 1'b0;
      @(negedge clk);
      check_gnt("lock", i, G_NONE);
    end
    step();
    cnt_req = 1'b1; cnt_we = 1'b1; cnt_wdata = 16'h0005;
    @(negedge clk);
    check_gnt("lock", 3, G_CNT);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 12'h024 || mem_wdata !== 16'h0005) begin
      errors++;
      $display("FAIL lock_write_cmd: we=%b addr=%h wd=%h, expected we=1 addr=024 wd=0005",
               mem_we, mem_addr, mem_wdata);
    end
    step();
    cnt_req = 1'b0; seq_addr = 12'h024;
    exp_q.push_back('{who: G_SEQ, data: 16'h0005});
    @(negedge clk);
    check_gnt("lock", 4, G_SEQ);
    step();
    idle();
    check_drained("lock_rmw");
  endtask

  task automatic test_reset_mid_lock();
    step();
    cnt_req = 1'b1; cnt_we = 1'b0; cnt_lock = 1'b1; cnt_addr = 12'h040;
    @(negedge clk);
    check_gnt("midlock", 0, G_CNT);
    #1;
    rst_n = 1'b0;
    idle();
    step();
    rst_n = 1'b1;
    seq_req = 1'b1; seq_we = 1'b0; seq_addr = 12'h024;
    exp_q.push_back('{who: G_SEQ, data: 16'h0005});
    @(negedge clk);
    check_gnt("midlock", 1, G_SEQ);
    step();
    idle();
    check_drained("reset_mid_lock");
  endtask

  initial begin
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    rst_n = 1'b0;
    idle();
    seq_we = 1'b0; cnt_we = 1'b0; io_we = 1'b0;
    seq_addr = '0; cnt_addr = '0; io_addr = '0;
    seq_wdata = '0; cnt_wdata = '0; io_wdata = '0;
    fork
      monitor_rvalid();
    join_none
    test_reset();
    preload(12'h040, 16'h1234);
    preload(12'h024, 16'h0007);
    test_seq_read();
    test_burst();
    test_starve();
    test_cnt_keeps_port();
    test_lock_rmw();
    test_reset_mid_lock();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single erasable-memory port between three requesters: the control-pulse sequencer (instruction fetch/execute), the counter-increment unit (PINC/MINC cycle stealing) and the DSKY I/O channel.
- Sits between the requesters and the synchronous single-port RAM.
- Issues at most one access per cycle and routes read data back to the requester that issued the read.
- Supports locked read-modify-write sequences for the counter unit, with bounded starvation of lower-priority requesters.

Parameters:
- ADDR_W, 12, memory word address width.
- DATA_W, 16, memory word width (15 data bits + parity).
- CNT_BURST, 4, maximum consecutive counter grants before the sequencer is granted one slot; 1..15.
- STARVE_LIM, 8, cycles I/O may wait before it is promoted above the sequencer; 1..15.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- seq_req, cnt_req, io_req  in  1 each  access request, held until granted.
- seq_we, cnt_we, io_we  in  1 each  1 = write, 0 = read.
- seq_addr, cnt_addr, io_addr  in  ADDR_W each  word address.
- seq_wdata, cnt_wdata, io_wdata  in  DATA_W each  write data.
- cnt_lock  in  1  set with a counter read; holds the port for the matching counter write.
- seq_gnt, cnt_gnt, io_gnt  out  1 each  access accepted this cycle; one-hot or zero.
- seq_rvalid, cnt_rvalid, io_rvalid  out  1 each  rdata valid for that requester.
- rdata  out  DATA_W  read data, broadcast to all requesters.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en with mem_we = 0.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - All gnt, rvalid, mem_en and mem_we are 0.
  - mem_addr, mem_wdata and rdata are 0.
  - FSM goes to ARB; burst and starve counters clear.
- Grant timing:
  - gnt, mem_en, mem_we, mem_addr and mem_wdata are combinational from the current requests and registered state, in the same cycle.
  - A requester sees gnt in the same cycle and may drop or change its request on the next edge.
  - Requests are level-held; the arbiter never queues.
- Read return:
  - A read granted in cycle N gives the matching rvalid = 1 in N+1, with rdata = mem_rdata.
  - rvalid is registered: one cycle, one-hot.
  - Back-to-back grants are allowed every cycle; throughput is 1 access/cycle.
- Priority in ARB, highest first:
  1. cnt, unless burst_cnt == CNT_BURST and seq_req = 1.
  2. io, if io_wait >= STARVE_LIM.
  3. seq.
  4. io.
- burst_cnt:
  - Increments on each cnt grant, saturating at CNT_BURST.
  - Clears on any seq grant, or on any cycle with cnt_req = 0.
- io_wait:
  - Increments each cycle io_req = 1 and io is not granted, saturating at 15.
  - Clears on io grant or when io_req = 0.
- FSM states:
  - ARB: normal arbitration. A cnt grant with cnt_we = 0 and cnt_lock = 1 moves to LOCK.
  - LOCK: only cnt may be granted. seq_gnt and io_gnt are forced to 0; io_wait still counts. A cnt grant with cnt_we = 1 returns to ARB. A cnt read with cnt_lock = 1 stays in LOCK. cnt_req = 0 stays in LOCK (no timeout).
  - Write grants do not enter LOCK. cnt_lock is ignored on writes in ARB.
- Boundary conditions:
  - No requests: mem_en = 0; mem_addr and mem_wdata hold their previous value.
  - All three requesting with counters at reset: cnt granted.
  - Burst limit reached with seq idle: cnt keeps the port.
  - Starved io vs active cnt burst below limit: cnt wins; io is promoted only above seq.
  - Reset mid-LOCK: returns to ARB and clears pending rvalid; any in-flight read data is discarded.
  - Write to address X and read of X on the next cycle: the read returns the new data, which relies on RAM write-first behaviour. The arbiter adds no bypass.

Decomposition:
- Shared package `agc_mem_pkg`:
  - ADDR_W and DATA_W defaults.
  - Requester index constants REQ_SEQ = 0, REQ_CNT = 1, REQ_IO = 2.
  - FSM state encoding ARB = 1'b0, LOCK = 1'b1.
- One sub-module `prio_select3`: combinational 3-way select taking a request vector and a promotion vector, producing a one-hot grant. Counters, FSM and muxes live in the top module.

Test Plan:
- Reset: assert rst_n = 0 with all req = 1 → all gnt, rvalid, mem_en = 0. Release → cnt_gnt = 1 in the first cycle.
- seq read at 12'h040 with RAM preloaded 16'h1234 → seq_gnt in cycle N, mem_addr = 12'h040, mem_we = 0; seq_rvalid = 1 and rdata = 16'h1234 in N+1.
- cnt_req and seq_req held continuously, CNT_BURST = 4 → grant pattern cnt,cnt,cnt,cnt,seq,cnt,cnt,cnt,cnt,seq.
- seq_req held continuously plus io_req, STARVE_LIM = 8 → seq granted 8 cycles, then io_gnt on cycle 9; io_wait then clears.
- Locked RMW: cnt read 12'h024 with cnt_lock = 1 while seq_req = 1; cnt writes 16'h0005 three cycles later → seq_gnt = 0 throughout; cnt_rvalid in N+1; return to ARB after the write; seq granted next cycle.
- Reset mid-LOCK, then seq read → seq_gnt granted immediately; no stale cnt_rvalid appears.
